// File: rtl/mac_compute.sv
// mac_compute: matrix multiply stage that sits behind the input memory block.
// Once matrices_loaded is seen, it reads A (M x K) and B (K x N) through the
// memory block's 1-cycle-latency read ports and builds each C[m][n] by
// multiply-accumulate. Results leave on an AXI-Stream master in row-major
// order, and compute_finished pulses once after the last beat is accepted.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   matrices_loaded    A/B memories hold a valid pair (sampled in IDLE only)
//   K                  inner dimension, stable while matrices_loaded=1
//   A_read_addr/A_data A read port (data valid one cycle after address)
//   B_read_addr/B_data B read port (data valid one cycle after address)
//   compute_finished   one-cycle pulse after the final result handshake
//   AXIS_TDATA/TVALID  result stream, held stable until accepted
//   AXIS_TREADY        downstream ready
module mac_compute #(
  parameter int INW  = 12,
  parameter int OUTW = 32,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  input  logic signed [INW-1:0]  A_data,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  input  logic signed [INW-1:0]  B_data,
  output logic                   compute_finished,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY
);

  localparam int M_BITS = (M > 1) ? $clog2(M) : 1;
  localparam int N_BITS = (N > 1) ? $clog2(N) : 1;
  localparam int PW     = 2 * INW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_OUTPUT = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [K_BITS-1:0]      k_lat;     // K captured at start of the job
  logic [K_BITS-1:0]      k;
  logic [M_BITS-1:0]      m;
  logic [N_BITS-1:0]      n;
  logic [A_ADDR_BITS-1:0] row_base;  // m*K, kept incrementally
  logic [OUTW-1:0]        acc;
  logic                   cooldown;  // blocks a restart in the cycle right after FINISH

  logic                   start;
  logic                   hs;
  logic                   last_elem;
  logic                   last_k;
  logic signed [PW-1:0]   a_ext;
  logic signed [PW-1:0]   b_ext;
  logic signed [PW-1:0]   prod;
  logic [OUTW-1:0]        prod_ext;

  assign start     = matrices_loaded && !cooldown;
  assign hs        = AXIS_TVALID && AXIS_TREADY;
  assign last_elem = (m == M_BITS'(M - 1)) && (n == N_BITS'(N - 1));
  assign last_k    = (k == (k_lat - 1'b1));

  // Full-precision signed product, then sign-extended to accumulator width.
  assign a_ext    = {{(PW - INW){A_data[INW-1]}}, A_data};
  assign b_ext    = {{(PW - INW){B_data[INW-1]}}, B_data};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(OUTW - PW){prod[PW-1]}}, prod};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (K == '0) ? S_OUTPUT : S_ISSUE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (last_k) begin
          state_next = S_DRAIN;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_DRAIN: begin
        state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (hs) begin
          if (last_elem) begin
            state_next = S_FINISH;
          end else if (k_lat == '0) begin
            state_next = S_OUTPUT;   // K=0: every result is zero, no reads needed
          end else begin
            state_next = S_ISSUE;
          end
        end else begin
          state_next = S_OUTPUT;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: counters, read addresses, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_lat            <= '0;
      k                <= '0;
      m                <= '0;
      n                <= '0;
      row_base         <= '0;
      acc              <= '0;
      cooldown         <= 1'b0;
      A_read_addr      <= '0;
      B_read_addr      <= '0;
      AXIS_TDATA       <= '0;
      AXIS_TVALID      <= 1'b0;
      compute_finished <= 1'b0;
    end else begin
      cooldown         <= (state == S_FINISH);
      compute_finished <= (state_next == S_FINISH);
      case (state)
        S_IDLE: begin
          if (start) begin
            k_lat       <= K;
            k           <= '0;
            m           <= '0;
            n           <= '0;
            row_base    <= '0;
            acc         <= '0;
            A_read_addr <= '0;
            B_read_addr <= '0;
            if (K == '0) begin
              AXIS_TDATA  <= '0;
              AXIS_TVALID <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Data for address k-1 arrives while address k is on the bus.
          if (k != '0) begin
            acc <= acc + prod_ext;
          end
          if (!last_k) begin
            k           <= k + 1'b1;
            A_read_addr <= A_read_addr + 1'b1;
            B_read_addr <= B_read_addr + B_ADDR_BITS'(N);
          end
        end
        S_DRAIN: begin
          acc         <= acc + prod_ext;
          AXIS_TDATA  <= acc + prod_ext;
          AXIS_TVALID <= 1'b1;
        end
        S_OUTPUT: begin
          if (hs) begin
            acc <= '0;
            k   <= '0;
            if (last_elem) begin
              AXIS_TVALID <= 1'b0;
            end else begin
              if (k_lat != '0) begin
                AXIS_TVALID <= 1'b0;
              end
              if (n == N_BITS'(N - 1)) begin
                n           <= '0;
                m           <= m + 1'b1;
                row_base    <= row_base + A_ADDR_BITS'(k_lat);
                A_read_addr <= row_base + A_ADDR_BITS'(k_lat);
                B_read_addr <= '0;
              end else begin
                n           <= n + 1'b1;
                A_read_addr <= row_base;
                B_read_addr <= B_ADDR_BITS'(n) + 1'b1;
              end
            end
          end
        end
        S_FINISH: begin
          acc <= '0;
        end
        default: begin
          acc <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_compute.md
Name: mac_compute

Overview:
- Compute stage directly downstream of the input memory block.
- Waits for matrices_loaded, then reads A (M x K) and B (K x N) through the memory block's synchronous read ports and forms C = A*B by multiply-accumulate.
- Streams the M*N results out on an AXI-Stream master, row-major.
- Pulses compute_finished back to the memory block so the next matrix pair can load.

Parameters:
- INW, 12, signed input element width.
- OUTW, 32, output/accumulator width.
- M, 7, rows of A and C.
- N, 9, columns of B and C.
- MAXK, 8, maximum inner dimension.
- K_BITS, $clog2(MAXK+1), localparam.
- A_ADDR_BITS, $clog2(M*MAXK), localparam.
- B_ADDR_BITS, $clog2(MAXK*N), localparam.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- matrices_loaded  in  1  A/B memories full and valid.
- K  in  K_BITS  inner dimension; stable while matrices_loaded=1.
- A_read_addr  out  A_ADDR_BITS  A read address.
- A_data  in  INW  signed A word, valid 1 cycle after address.
- B_read_addr  out  B_ADDR_BITS  B read address.
- B_data  in  INW  signed B word, valid 1 cycle after address.
- compute_finished  out  1  one-cycle pulse after last result accepted.
- AXIS_TDATA  out  OUTW  signed result C[m][n].
- AXIS_TVALID  out  1  result valid.
- AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Memory layout:
  - A[m][k] at address m*K+k.
  - B[k][n] at address k*N+n.
  - Both reads have 1-cycle latency (registered data_out).
- Reset (async, any state): state=IDLE; m, n, k counters = 0; accumulator = 0; AXIS_TVALID=0; AXIS_TDATA=0; compute_finished=0; read addresses = 0.
- States: IDLE, ISSUE, DRAIN, OUTPUT, FINISH.
- IDLE: on matrices_loaded=1, latch K, clear accumulator, m=n=k=0, go to ISSUE. If K=0, go directly to OUTPUT with TDATA=0.
- ISSUE, cycle t0+k for k=0..K-1:
  - Drive A_read_addr=m*K+k and B_read_addr=k*N+n.
  - From cycle t0+1 onward, accumulate sign_ext(A_data)*sign_ext(B_data), arriving from the previous cycle's address.
  - After k=K-1 is issued, go to DRAIN.
- DRAIN, one cycle: accumulate the final product; register the sum into AXIS_TDATA; go to OUTPUT.
- OUTPUT:
  - AXIS_TVALID=1 from cycle t0+K+1 for K>=1.
  - TDATA/TVALID are held stable until AXIS_TVALID&&AXIS_TREADY.
  - On the handshake cycle: clear accumulator and advance n; on n wrap to 0, advance m.
  - If another element remains, the next cycle is ISSUE with k=0.
  - If (m,n)=(M-1,N-1) was just accepted, go to FINISH.
- FINISH: compute_finished=1 for exactly one cycle, then IDLE. matrices_loaded is sampled again only from IDLE. A still-high matrices_loaded in the cycle after FINISH is ignored for one cycle; the memory block drops it in response to compute_finished.
- Arithmetic:
  - Each product is 2*INW bits signed, sign-extended to OUTW.
  - The accumulator wraps modulo 2^OUTW; there is no saturation and no overflow flag.
- Throughput: K+2 cycles per element when AXIS_TREADY is held high.
- Boundary cases:
  - TREADY low indefinitely: state holds; no reads are issued.
  - Reset mid-element: no partial result or compute_finished is emitted.
  - matrices_loaded toggling mid-compute is ignored.

Test Plan:
1. K=1, A all 1, B all 1, TREADY=1 -> 63 beats of TDATA=1, one beat every 3 cycles. compute_finished pulses once, 1 cycle after the 63rd handshake.
2. K=8, all A=-2048, all B=-2048 -> every beat TDATA=33554432. K=8 with A=2047, B=-2048 -> every beat TDATA=-33538048.
3. K=3, A[m][k]=m+k, B[k][n]=k-n -> all 63 beats match a golden row-major C, including negative results.
4. Same data as 3 with TREADY random at 30% -> identical 63-value sequence. TDATA/TVALID never change while TVALID=1 and TREADY=0; no beats dropped or duplicated.
5. K=0 -> 63 beats of TDATA=0, no read dependence, one compute_finished pulse.
6. Assert reset during ISSUE of element 20 -> TVALID=0 and compute_finished=0 immediately, state IDLE. A subsequent matrices_loaded restarts at C[0][0].
